rgb_led_sched: RTL and testbench

Status-LED scheduler that shares the single on-chip RGB LED driver among several event sources, such as CAN RX, CAN TX, bus error and bus-off. Each source issues a colour request over a valid/ready handshake. A round-robin arbiter grants one request at a time and shows its colour for a fixed hold time, followed by a dark gap. Outputs are three PWM signals that feed the RGB0PWM/RGB1PWM/RGB2PWM pins of the LED driver primitive.

---
 rtl/rgb_led_sched_pkg.sv | 24 ++
 rtl/rgb_led_sched_rr_arbiter.sv | 33 +++
 rtl/rgb_led_sched.sv | 172 +++++++++++++++++
 tb/tb_rgb_led_sched.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_led_sched_pkg.sv
// Shared encodings for the status-LED scheduler: FSM states and colour constants.
package rgb_led_sched_pkg;

  // Scheduler states; the encodings are fixed so they can be matched in debug captures.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccept = 2'd1,
    StShow   = 2'd2,
    StGap    = 2'd3
  } state_e;

  // Colours are packed {b,g,r}.
  localparam logic [2:0] ColOff   = 3'b000;
  localparam logic [2:0] ColRed   = 3'b001;
  localparam logic [2:0] ColGreen = 3'b010;
  localparam logic [2:0] ColBlue  = 3'b100;
  localparam logic [2:0] ColWhite = 3'b111;

  // Larger of two counts, used to size the shared hold/gap counter.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rgb_led_sched_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above the pointer, with wrap.
module rgb_led_sched_rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned PtrW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PtrW-1:0]  i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [PtrW-1:0]  o_idx,
  output logic             o_valid
);

  int unsigned w_j;

  // Scan N_REQ positions starting at the pointer; the first hit wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_j     = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      w_j = 32'(i_ptr) + k;
      // Explicit wrap so non-power-of-two N_REQ never indexes past the vector.
      if (w_j >= N_REQ) w_j = w_j - N_REQ;
      if (!o_valid && i_req[w_j]) begin
        o_valid      = 1'b1;
        o_grant[w_j] = 1'b1;
        o_idx        = PtrW'(w_j);
      end
    end
  end

endmodule

// File: rtl/rgb_led_sched.sv
// Shares one RGB LED driver among N_REQ event sources: round-robin grant, timed
// display of the granted colour, a dark gap, then the next grant.
module rgb_led_sched
  import rgb_led_sched_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned PWM_BITS   = 8,
  parameter int unsigned TICK_DIV   = 16000,
  parameter int unsigned HOLD_TICKS = 50,
  parameter int unsigned GAP_TICKS  = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [3*N_REQ-1:0]  req_color,
  input  logic [PWM_BITS-1:0] duty,
  input  logic                idle_en,
  input  logic [2:0]          idle_color,
  output logic                pwm_r,
  output logic                pwm_g,
  output logic                pwm_b,
  output logic [N_REQ-1:0]    grant,
  output logic                busy
);

  localparam int unsigned PtrW  = $clog2(N_REQ);
  localparam int unsigned PresW = $clog2(TICK_DIV);
  // One counter serves both SHOW and GAP, so it is sized for the longer of the two.
  localparam int unsigned CntW  = $clog2(max_u(HOLD_TICKS, GAP_TICKS) + 1);

  state_e             r_state, w_state_d;
  logic [PresW-1:0]   r_presc;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [CntW-1:0]    r_cnt, w_cnt_d;
  logic [PtrW-1:0]    r_ptr, w_ptr_d;
  logic [PtrW-1:0]    r_sel, w_sel_d;
  logic [N_REQ-1:0]   r_sel_oh, w_sel_oh_d;
  logic [2:0]         r_color, w_color_d;
  logic [N_REQ-1:0]   r_grant, w_grant_d;
  logic [2:0]         r_pwm;
  logic [2:0]         w_disp;
  logic [N_REQ-1:0]   w_ready;
  logic               w_tick;
  logic               w_on;
  logic [N_REQ-1:0]   w_arb_oh;
  logic [PtrW-1:0]    w_arb_idx;
  logic               w_arb_valid;

  rgb_led_sched_rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_arb (
    .i_req  (req_valid),
    .i_ptr  (r_ptr),
    .o_grant(w_arb_oh),
    .o_idx  (w_arb_idx),
    .o_valid(w_arb_valid)
  );

  assign w_tick = (r_presc == PresW'(TICK_DIV - 1));
  assign w_on   = (r_pwm_cnt < duty);

  // Free-running tick prescaler; deliberately not realigned on state changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else             r_presc <= r_presc + PresW'(1);
  end

  // Free-running PWM counter, wraps modulo 2^PWM_BITS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pwm_cnt <= '0;
    else        r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
  end

  // FSM and datapath state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_ptr    <= '0;
      r_sel    <= '0;
      r_sel_oh <= '0;
      r_color  <= ColOff;
      r_grant  <= '0;
    end else begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_ptr    <= w_ptr_d;
      r_sel    <= w_sel_d;
      r_sel_oh <= w_sel_oh_d;
      r_color  <= w_color_d;
      r_grant  <= w_grant_d;
    end
  end

  // Next-state, handshake and displayed-colour selection.
  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_ptr_d    = r_ptr;
    w_sel_d    = r_sel;
    w_sel_oh_d = r_sel_oh;
    w_color_d  = r_color;
    w_grant_d  = r_grant;
    w_ready    = '0;
    w_disp     = ColOff;
    unique case (r_state)
      StIdle: begin
        w_disp = idle_en ? idle_color : ColOff;
        if (w_arb_valid) begin
          w_state_d  = StAccept;
          w_sel_d    = w_arb_idx;
          w_sel_oh_d = w_arb_oh;
        end
      end
      StAccept: begin
        // Selection was made from valid sampled last cycle; a drop now is ignored.
        w_ready   = r_sel_oh;
        w_color_d = req_color[3*int'(r_sel) +: 3];
        w_grant_d = r_sel_oh;
        w_ptr_d   = (r_sel == PtrW'(N_REQ - 1)) ? '0 : r_sel + PtrW'(1);
        w_cnt_d   = '0;
        w_state_d = StShow;
      end
      StShow: begin
        w_disp = r_color;
        if (w_tick) begin
          if (r_cnt == CntW'(HOLD_TICKS - 1)) begin
            w_cnt_d   = '0;
            w_state_d = StGap;
          end else begin
            w_cnt_d = r_cnt + CntW'(1);
          end
        end
      end
      StGap: begin
        if (w_tick) begin
          if (r_cnt == CntW'(GAP_TICKS - 1)) begin
            w_cnt_d   = '0;
            w_grant_d = '0;
            // Pending requests go straight to ACCEPT without an IDLE cycle.
            if (w_arb_valid) begin
              w_state_d  = StAccept;
              w_sel_d    = w_arb_idx;
              w_sel_oh_d = w_arb_oh;
            end else begin
              w_state_d = StIdle;
            end
          end else begin
            w_cnt_d = r_cnt + CntW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // Registered PWM outputs so the driver never sees combinational glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pwm <= '0;
    else        r_pwm <= w_disp & {3{w_on}};
  end

  assign pwm_r     = r_pwm[0];
  assign pwm_g     = r_pwm[1];
  assign pwm_b     = r_pwm[2];
  assign grant     = r_grant;
  assign req_ready = w_ready;
  assign busy      = (r_state != StIdle);

endmodule

// File: tb/tb_rgb_led_sched.sv
// Self-checking bench for rgb_led_sched: expected grant order is queued as requests
// are driven and compared against each observed ready handshake.
module tb_rgb_led_sched;
  import rgb_led_sched_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned PB = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [3*NR-1:0] req_color;
  logic [PB-1:0]   duty;
  logic            idle_en;
  logic [2:0]      idle_color;
  logic            pwm_r, pwm_g, pwm_b;
  logic [NR-1:0]   grant;
  logic            busy;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  rgb_led_sched #(
    .N_REQ(NR), .PWM_BITS(PB), .TICK_DIV(4), .HOLD_TICKS(3), .GAP_TICKS(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_color(req_color), .duty(duty), .idle_en(idle_en), .idle_color(idle_color),
    .pwm_r(pwm_r), .pwm_g(pwm_g), .pwm_b(pwm_b), .grant(grant), .busy(busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Count high cycles of each output over n consecutive samples.
  task automatic count_pwm(input int n, output int cr, output int cg, output int cb,
                           output int cbusy);
    cr = 0; cg = 0; cb = 0; cbusy = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      cr += int'(pwm_r);
      cg += int'(pwm_g);
      cb += int'(pwm_b);
      cbusy += int'(busy);
    end
  endtask

  // Wait for a ready pulse and compare the accepted index with the scoreboard head.
  task automatic wait_hs(input string tag, input int budget, output int idx,
                         output int idle_cyc);
    int exp;
    idx = -1;
    idle_cyc = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        check_eq({tag, "_onehot"}, $countones(req_ready), 1);
        for (int i = 0; i < NR; i++) if (req_ready[i]) idx = i;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : -2;
        check_eq({tag, "_idx"}, idx, exp);
        check_eq({tag, "_grant_clear"}, grant, 0);
        return;
      end
      if (!busy) idle_cyc++;
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : -2;
    check_eq({tag, "_timeout_idx"}, idx, exp);
  endtask

  // Cycle after the handshake: ready must be gone and grant must name the winner.
  task automatic post_hs(input string tag, input int idx);
    @(negedge clk);
    check_eq({tag, "_ready_1cyc"}, req_ready, 0);
    check_eq({tag, "_grant"}, grant, (idx >= 0) ? (32'd1 << idx) : 32'd0);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (!busy) return;
    end
    check_eq({tag, "_idle_timeout"}, busy, 0);
  endtask

  initial begin
    int cr, cg, cb, cbusy, idx, idle, len, s, rc, rgap, gb;
    int r_h[64];
    int gb_h[64];

    req_valid  = '0;
    req_color  = {ColWhite, ColBlue, ColGreen, ColRed};
    duty       = '0;
    idle_en    = 1'b0;
    idle_color = ColOff;

    // Reset values, in and out of reset.
    repeat (3) @(negedge clk);
    check_eq("rst_pwm", {pwm_b, pwm_g, pwm_r}, 0);
    check_eq("rst_grant", grant, 0);
    check_eq("rst_ready", req_ready, 0);
    check_eq("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rel_pwm", {pwm_b, pwm_g, pwm_r}, 0);
    check_eq("rel_busy", busy, 0);

    // Duty boundaries using the idle colour.
    idle_en = 1'b1;
    idle_color = ColWhite;
    duty = 4'd0;
    repeat (2) @(negedge clk);
    count_pwm(32, cr, cg, cb, cbusy);
    check_eq("duty0_r", cr, 0);
    check_eq("duty0_g", cg, 0);
    check_eq("duty0_b", cb, 0);
    duty = 4'd15;
    repeat (2) @(negedge clk);
    count_pwm(32, cr, cg, cb, cbusy);
    check_eq("duty15_r", cr, 30);
    check_eq("duty15_g", cg, 30);
    check_eq("duty15_b", cb, 30);

    // Idle colour green at half duty, nothing pending.
    idle_color = ColGreen;
    duty = 4'd8;
    repeat (2) @(negedge clk);
    count_pwm(32, cr, cg, cb, cbusy);
    check_eq("idle_g", cg, 16);
    check_eq("idle_r", cr, 0);
    check_eq("idle_b", cb, 0);
    check_eq("idle_busy", cbusy, 0);

    // Single red request from requester 0 while idle shows green.
    req_valid = 4'b0001;
    exp_q.push_back(0);
    wait_hs("single", 20, idx, idle);
    req_valid = '0;
    len = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 0) check_eq("single_ready_1cyc", req_ready, 0);
      if (grant == '0) break;
      if (c == 0) check_eq("single_grant", grant, 4'b0001);
      r_h[len] = int'(pwm_r);
      gb_h[len] = int'(pwm_g) + int'(pwm_b);
      len++;
    end
    check_eq("single_idle_after", busy, 0);
    check_eq("single_len_17_20", (len >= 17 && len <= 20), 1);
    s = len - 8;
    rc = 0; rgap = 0; gb = 0;
    for (int i = 1; i < len; i++) begin
      if (i <= s) rc += r_h[i];
      else        rgap += r_h[i];
      gb += gb_h[i];
    end
    check_eq("single_red_lo", rc >= s - 8, 1);
    check_eq("single_red_hi", rc <= 8, 1);
    check_eq("single_gap_dark", rgap, 0);
    check_eq("single_gb_off", gb, 0);

    // Requester 2 (pointer now 1), then reset in the middle of its display.
    duty = 4'd15;
    req_valid = 4'b0100;
    exp_q.push_back(2);
    wait_hs("pre_rst", 20, idx, idle);
    req_valid = '0;
    post_hs("pre_rst", idx);
    repeat (2) @(negedge clk);
    check_eq("pre_rst_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_pwm", {pwm_b, pwm_g, pwm_r}, 0);
    check_eq("async_rst_grant", grant, 0);
    check_eq("async_rst_ready", req_ready, 0);
    check_eq("async_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_en = 1'b0;
    duty = 4'd8;
    @(negedge clk);

    // All four held: order restarts at 0 and rotates with no IDLE between displays.
    req_valid = 4'b1111;
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(2);
    exp_q.push_back(3);
    exp_q.push_back(0);
    for (int k = 0; k < 5; k++) begin
      wait_hs("rr", 60, idx, idle);
      if (k > 0) check_eq("rr_no_idle", idle, 0);
      if (k == 4) req_valid = '0;
      post_hs("rr", idx);
    end
    wait_idle("rr", 40);

    // Late request: requester 1 arrives during the display of requester 3.
    req_valid = 4'b1000;
    exp_q.push_back(3);
    wait_hs("late3", 20, idx, idle);
    req_valid = '0;
    post_hs("late3", idx);
    repeat (2) @(negedge clk);
    req_valid = 4'b0010;
    exp_q.push_back(1);
    wait_hs("late1", 40, idx, idle);
    check_eq("late1_no_idle", idle, 0);
    req_valid = '0;
    post_hs("late1", idx);
    wait_idle("late1", 40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
